// File: rtl/set_assoc_cache.sv
// N-way set-associative write-through, no-write-allocate data cache with round-robin victims.
// Load hits complete in the request cycle. Misses and stores take 1 cycle plus the memory latency and hold the core until mem_ack_i.
module set_assoc_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 4,
    parameter int WAYS       = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic                  byte_op_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  ready_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic                  mem_byte_op_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   data_q  [SETS][WAYS];
    logic [TAG_W-1:0]        tag_q   [SETS][WAYS];
    logic [WAYS-1:0]         valid_q [SETS];
    logic [WAY_W-1:0]        ptr_q   [SETS];
    logic [31:0]             hit_cnt;
    logic [31:0]             miss_cnt;

    logic [IDX_W-1:0]        idx;
    logic [TAG_W-1:0]        tag;
    logic [1:0]              off;
    logic                    hit;
    logic [WAY_W-1:0]        hit_way;
    logic [DATA_WIDTH-1:0]   hit_data;
    logic                    has_inv;
    logic [WAY_W-1:0]        inv_way;
    logic [WAY_W-1:0]        victim;
    logic [WAY_W-1:0]        ptr_next;
    logic [DATA_WIDTH-1:0]   ld_word;
    logic                    fill_we;
    logic                    store_we;

    assign idx = addr_i[2 +: IDX_W];
    assign tag = addr_i[ADDR_WIDTH-1 -: TAG_W];
    assign off = addr_i[1:0];

    // Tags only compare against valid ways, so at most one way can match.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit      = 1'b1;
                hit_way  = WAY_W'(w);
                hit_data = data_q[idx][w];
            end
        end
    end

    // Descending scan leaves the lowest-index invalid way selected.
    always_comb begin
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) inv_way = WAY_W'(w);
        end
    end

    assign has_inv  = ~&valid_q[idx];
    assign victim   = has_inv ? inv_way : ptr_q[idx];
    assign ptr_next = (ptr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : ptr_q[idx] + 1'b1;
    assign ld_word  = (state == FILL) ? mem_rdata_i : hit_data;
    assign fill_we  = (state == FILL) && mem_ack_i;
    assign store_we = (state == WRITE) && mem_ack_i && hit;

    always_comb begin
        ready_o       = 1'b0;
        rdata_o       = '0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_byte_op_o = 1'b0;
        mem_addr_o    = '0;
        case (state)
            IDLE: ready_o = req_i && !flush_i && !we_i && hit;
            FILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {addr_i[ADDR_WIDTH-1:2], 2'b00};
                ready_o    = mem_ack_i;
            end
            WRITE: begin
                mem_req_o     = 1'b1;
                mem_we_o      = 1'b1;
                mem_byte_op_o = byte_op_i;
                mem_addr_o    = addr_i;
                ready_o       = mem_ack_i;
            end
            default: ;
        endcase
        if (ready_o && !we_i)
            rdata_o = byte_op_i ? {24'b0, ld_word[off*8 +: 8]} : ld_word;
    end

    assign mem_wdata_o  = wdata_i;
    assign hit_count_o  = hit_cnt;
    assign miss_count_o = miss_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (flush_i) begin
                        for (int s = 0; s < SETS; s++) begin
                            valid_q[s] <= '0;
                            ptr_q[s]   <= '0;
                        end
                    end else if (req_i) begin
                        if (we_i)     state   <= WRITE;
                        else if (hit) hit_cnt <= hit_cnt + 32'd1;
                        else          state   <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ack_i) begin
                        valid_q[idx][victim] <= 1'b1;
                        if (!has_inv) ptr_q[idx] <= ptr_next;
                        miss_cnt <= miss_cnt + 32'd1;
                        state    <= IDLE;
                    end
                end
                WRITE: if (mem_ack_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Line payload needs no reset: valid bits gate every use of it.
    always_ff @(posedge clk_i) begin
        if (fill_we) begin
            data_q[idx][victim] <= mem_rdata_i;
            tag_q[idx][victim]  <= tag;
        end else if (store_we) begin
            for (int b = 0; b < 4; b++) begin
                if (!byte_op_i)
                    data_q[idx][hit_way][b*8 +: 8] <= wdata_i[b*8 +: 8];
                else if (off == 2'(b))
                    data_q[idx][hit_way][b*8 +: 8] <= wdata_i[7:0];
            end
        end
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache with a latency-programmable memory responder.
module tb_set_assoc_cache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        bop = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        flush = 1'b0;
    logic [31:0] rdata;
    logic        ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_bop;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_cmp = 0;
    int n_err = 0;

    set_assoc_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SETS(4), .WAYS(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .byte_op_i(bop),
        .addr_i(addr), .wdata_i(wdata), .flush_i(flush), .rdata_o(rdata),
        .ready_o(ready), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_byte_op_o(mem_bop), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .hit_count_o(hit_count), .miss_count_o(miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one access, acks 'lat' cycles after mem_req is first seen; cyc = -1 on timeout.
    task automatic access(input logic w, input logic b, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] md, input int lat,
                          output logic [31:0] rd, output int cyc, output logic sm,
                          output logic mwe, output logic mb, output logic [31:0] ma,
                          output logic [31:0] mwd);
        int  wc;
        bit  done;
        wc = 0; done = 0; sm = 0; mwe = 0; mb = 0; ma = '0; mwd = '0; rd = '0; cyc = -1;
        @(negedge clk);
        req = 1'b1; we = w; bop = b; addr = a; wdata = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (mem_req) begin
                sm = 1; mwe = mem_we; mb = mem_bop; ma = mem_addr; mwd = mem_wdata;
                if (wc == lat) begin
                    mem_ack = 1'b1; mem_rdata = md;
                    #1;
                end else begin
                    wc++;
                end
            end
            if (ready) begin
                rd = rdata; cyc = c; done = 1;
            end
            @(negedge clk);
            mem_ack = 1'b0;
        end
        req = 1'b0; we = 1'b0; bop = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
    endtask

    logic [31:0] rd, ma, mwd;
    logic        sm, mwe, mb;
    int          cyc;

    initial begin
        #12;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_hits", hit_count, 32'd0);
        check("rst_misses", miss_count, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Miss with 2-cycle memory latency, then a 0-cycle hit.
        access(0, 0, 32'h100, 0, 32'hDEADBEEF, 2, rd, cyc, sm, mwe, mb, ma, mwd);
        check("miss_data", rd, 32'hDEADBEEF);
        check("miss_latency", 32'(cyc), 32'd3);
        check("miss_addr", ma, 32'h100);
        check("miss_we", 32'(mwe), 32'd0);
        access(0, 0, 32'h100, 0, 32'h0, 0, rd, cyc, sm, mwe, mb, ma, mwd);
        check("hit_data", rd, 32'hDEADBEEF);
        check("hit_latency", 32'(cyc), 32'd0);
        check("hit_no_mem", 32'(sm), 32'd0);
        check("cnt_hits1", hit_count, 32'd1);
        check("cnt_miss1", miss_count, 32'd1);

        // Store-hit updates the line; byte loads select by offset.
        access(1, 0, 32'h100, 32'h11223344, 0, 1, rd, cyc, sm, mwe, mb, ma, mwd);
        check("st_latency", 32'(cyc), 32'd2);
        access(0, 1, 32'h103, 0, 0, 0, rd, cyc, sm, mwe, mb, ma, mwd);
        check("bl_103", rd, 32'h00000011);
        check("bl_103_no_mem", 32'(sm), 32'd0);
        access(0, 1, 32'h100, 0, 0, 0, rd, cyc, sm, mwe, mb, ma, mwd);
        check("bl_100", rd, 32'h00000044);

        access(1, 0, 32'h100, 32'hCAFEF00D, 0, 0, rd, cyc, sm, mwe, mb, ma, mwd);
        check("sw_we", 32'(mwe), 32'd1);
        check("sw_bop", 32'(mb), 32'd0);
        check("sw_addr", ma, 32'h100);
        check("sw_wdata", mwd, 32'hCAFEF00D);
        access(1, 1, 32'h101, 32'h000000AB, 0, 0, rd, cyc, sm, mwe, mb, ma, mwd);
        check("sb_bop", 32'(mb), 32'd1);
        check("sb_addr", ma, 32'h101);
        access(0, 0, 32'h100, 0, 0, 0, rd, cyc, sm, mwe, mb, ma, mwd);
        check("reload", rd, 32'hCAFEAB0D);
        check("reload_hit", 32'(sm), 32'd0);

        // Store miss must not allocate.
        access(1, 0, 32'h200, 32'h01020304, 0, 0, rd, cyc, sm, mwe, mb, ma, mwd);
        check("stmiss_addr", ma, 32'h200);
        access(0, 0, 32'h200, 0, 32'h55, 0, rd, cyc, sm, mwe, mb, ma, mwd);
        check("ld_after_stmiss", 32'(sm), 32'd1);
        check("ld_after_stmiss_d", rd, 32'h55);

        // Flush wins over a concurrent request.
        @(negedge clk);
        req = 1'b1; we = 1'b0; bop = 1'b0; addr = 32'h100; flush = 1'b1;
        #1;
        check("flush_ready", 32'(ready), 32'd0);
        @(negedge clk); req = 1'b0; flush = 1'b0;
        access(0, 0, 32'h100, 0, 32'h77, 0, rd, cyc, sm, mwe, mb, ma, mwd);
        check("post_flush_miss", 32'(sm), 32'd1);

        // Round-robin replacement in set 0.
        do_flush();
        access(0, 0, 32'h000, 0, 32'hA0, 1, rd, cyc, sm, mwe, mb, ma, mwd);
        access(0, 0, 32'h010, 0, 32'hA1, 1, rd, cyc, sm, mwe, mb, ma, mwd);
        access(0, 0, 32'h020, 0, 32'hA2, 1, rd, cyc, sm, mwe, mb, ma, mwd);
        check("rr_fill_020", rd, 32'hA2);
        access(0, 0, 32'h010, 0, 0, 0, rd, cyc, sm, mwe, mb, ma, mwd);
        check("rr_010_hit", 32'(sm), 32'd0);
        check("rr_010_data", rd, 32'hA1);
        access(0, 0, 32'h000, 0, 32'hB0, 0, rd, cyc, sm, mwe, mb, ma, mwd);
        check("rr_000_miss", 32'(sm), 32'd1);
        access(0, 0, 32'h020, 0, 0, 0, rd, cyc, sm, mwe, mb, ma, mwd);
        check("rr_020_kept", 32'(sm), 32'd0);
        check("rr_020_data", rd, 32'hA2);
        access(0, 0, 32'h010, 0, 32'hB1, 0, rd, cyc, sm, mwe, mb, ma, mwd);
        check("rr_010_evicted", 32'(sm), 32'd1);
        check("cnt_hits_total", hit_count, 32'd6);
        check("cnt_miss_total", miss_count, 32'd8);

        // Reset in the middle of a fill.
        @(negedge clk);
        req = 1'b1; we = 1'b0; bop = 1'b0; addr = 32'h300;
        @(negedge clk); #1;
        check("fill_req_up", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_drops_req", 32'(mem_req), 32'd0);
        check("rst_hits_clr", hit_count, 32'd0);
        check("rst_miss_clr", miss_count, 32'd0);
        @(negedge clk); rst_n = 1'b1; req = 1'b0;
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h99;
        #1;
        check("late_ack_ignored", 32'(ready), 32'd0);
        @(negedge clk); mem_ack = 1'b0;
        access(0, 0, 32'h300, 0, 32'h12345678, 0, rd, cyc, sm, mwe, mb, ma, mwd);
        check("post_rst_miss", 32'(sm), 32'd1);
        check("post_rst_data", rd, 32'h12345678);
        check("post_rst_misses", miss_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
